// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: next-PC operations and FSM states.
package pc_sequencer_pkg;

  localparam int PC_W = 16;

  // Next-PC operation carried on pc_op; codes 6-7 are reserved and retire as NEXT.
  typedef enum logic [2:0] {
    OP_NEXT = 3'd0,
    OP_JREL = 3'd1,
    OP_JABS = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_HALT = 3'd5
  } pc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/pc_sequencer_call_stack.sv
// LIFO of return addresses. full/empty are combinational on the occupancy count,
// so the caller can decide push/pop legality in the same cycle it issues them.
module call_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]           cnt;
  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_idx;
  logic [AW-1:0]           rd_idx;

  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  assign wr_idx = AW'(cnt);
  assign rd_idx = AW'(cnt - CW'(1));
  assign dout   = mem[rd_idx];

  // Occupancy count; reset empties the stack. Illegal push/pop are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (push && !full)   cnt <= cnt + CW'(1);
    else if (pop && !empty)   cnt <= cnt - CW'(1);
  end

  // Entry storage; contents above the count are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer: fetches from memory at pc, presents ir to the datapath,
// and advances pc by the op reported alongside exec_done (incl. call/return).
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = 16'h0000,
  parameter int              STACK_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            mem_rd,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic [PC_W-1:0] mem_data,
  output logic [PC_W-1:0] ir,
  output logic            ir_valid,
  input  logic            exec_done,
  input  logic [2:0]      pc_op,
  input  logic [PC_W-1:0] pc_operand,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            stack_err
);

  state_e          state;
  pc_op_e          op;
  logic            retire;
  logic            stk_push;
  logic            stk_pop;
  logic            stk_full;
  logic            stk_empty;
  logic [PC_W-1:0] stk_dout;
  logic [PC_W-1:0] pc_inc;

  assign op       = pc_op_e'(pc_op);
  assign retire   = (state == ST_EXEC) && exec_done;
  assign pc_inc   = pc + 16'd1;
  assign stk_push = retire && (op == OP_CALL) && !stk_full;
  assign stk_pop  = retire && (op == OP_RET) && !stk_empty;
  assign mem_addr = pc;

  call_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_inc),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Sequencer FSM; all outputs registered so they change only with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc        <= RESET_VECTOR;
      ir        <= '0;
      ir_valid  <= 1'b0;
      mem_rd    <= 1'b0;
      halted    <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      ir_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          pc <= RESET_VECTOR;
          if (start) begin
            state  <= ST_FETCH;
            mem_rd <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (mem_ready) begin
            ir       <= mem_data;
            ir_valid <= 1'b1;
            mem_rd   <= 1'b0;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            state  <= ST_FETCH;
            mem_rd <= 1'b1;
            case (op)
              OP_JREL: pc <= pc + pc_operand;
              OP_JABS: pc <= pc_operand;
              OP_CALL: begin
                if (stk_full) begin
                  // Overflow is fatal: stop with pc pointing at the offending call.
                  state     <= ST_HALT;
                  mem_rd    <= 1'b0;
                  halted    <= 1'b1;
                  stack_err <= 1'b1;
                end else begin
                  pc <= pc_operand;
                end
              end
              OP_RET: begin
                if (stk_empty) begin
                  state     <= ST_HALT;
                  mem_rd    <= 1'b0;
                  halted    <= 1'b1;
                  stack_err <= 1'b1;
                end else begin
                  pc <= stk_dout;
                end
              end
              OP_HALT: begin
                state  <= ST_HALT;
                mem_rd <= 1'b0;
                halted <= 1'b1;
              end
              default: pc <= pc_inc;
            endcase
          end
        end
        default: ; // ST_HALT: terminal until reset
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a transaction-level reference (queue stack,
// plain 16-bit arithmetic) checked every cycle, plus literal spot checks.
module tb_pc_sequencer;

  localparam logic [15:0] RV    = 16'h0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        mem_ready = 1'b0;
  logic        exec_done = 1'b0;
  logic [15:0] mem_data = 16'h0;
  logic [15:0] pc_operand = 16'h0;
  logic [2:0]  pc_op = 3'd0;
  logic        mem_rd, ir_valid, halted, stack_err;
  logic [15:0] mem_addr, ir, pc;

  int checks = 0;
  int failures = 0;

  pc_sequencer #(.RESET_VECTOR(RV), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_data(mem_data), .ir(ir), .ir_valid(ir_valid),
    .exec_done(exec_done), .pc_op(pc_op), .pc_operand(pc_operand), .pc(pc),
    .halted(halted), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 fetching, 2 executing, 3 halted
  int          m_ph;
  logic [15:0] m_pc, m_ir;
  logic        m_irv, m_err;
  logic [15:0] m_stk[$];
  bit          chk_en = 1'b0;

  task automatic model_reset();
    m_ph = 0; m_pc = RV; m_ir = 16'h0; m_irv = 1'b0; m_err = 1'b0;
    m_stk.delete();
  endtask

  task automatic model_halt(input logic err);
    m_ph = 3;
    if (err) m_err = 1'b1;
  endtask

  task automatic model_step();
    m_irv = 1'b0;
    case (m_ph)
      0: if (start) m_ph = 1;
      1: if (mem_ready) begin m_ir = mem_data; m_irv = 1'b1; m_ph = 2; end
      2: if (exec_done) begin
        m_ph = 1;
        case (pc_op)
          3'd1: m_pc = m_pc + pc_operand;
          3'd2: m_pc = pc_operand;
          3'd3: if (m_stk.size() == DEPTH) model_halt(1'b1);
                else begin m_stk.push_back(m_pc + 16'd1); m_pc = pc_operand; end
          3'd4: if (m_stk.size() == 0) model_halt(1'b1);
                else m_pc = m_stk.pop_back();
          3'd5: model_halt(1'b0);
          default: m_pc = m_pc + 16'd1;
        endcase
      end
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) model_reset(); else model_step();

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_rd", mem_rd, m_ph == 1);
      chk("mem_addr", mem_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("ir", ir, m_ir);
      chk("ir_valid", ir_valid, m_irv);
      chk("halted", halted, m_ph == 3);
      chk("stack_err", stack_err, m_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic reset_pins(input string tag);
    chk({tag, "_pc"}, pc, 16'h0000);
    chk({tag, "_ir"}, ir, 16'h0000);
    chk({tag, "_ir_valid"}, ir_valid, 1'b0);
    chk({tag, "_mem_rd"}, mem_rd, 1'b0);
    chk({tag, "_halted"}, halted, 1'b0);
    chk({tag, "_stack_err"}, stack_err, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    start = 1'b0; mem_ready = 1'b0; exec_done = 1'b0; pc_op = 3'd0; pc_operand = 16'h0;
    #1 reset_pins("rst");
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic go();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // One instruction: fetch completes immediately, datapath retires in the ir_valid cycle.
  task automatic instr(input logic [2:0] op, input logic [15:0] opd, input logic [15:0] data);
    mem_ready = 1'b1; mem_data = data; tick();
    chk("exec_ir_valid", ir_valid, 1'b1);
    chk("exec_ir", ir, data);
    mem_ready = 1'b0; exec_done = 1'b1; pc_op = op; pc_operand = opd; tick();
    exec_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Sequential run: mem_ready in IDLE is ignored, then NEXT x4 fetches 0..4.
    do_reset();
    mem_ready = 1'b1; tick(); tick(); mem_ready = 1'b0;
    chk("idle_mem_rd", mem_rd, 1'b0);
    go();
    for (int k = 0; k < 5; k++) begin
      chk("seq_addr", mem_addr, 16'(k));
      if (k < 4) instr(3'd0, 16'h0, 16'hA000 + 16'(k));
    end

    // Modulo arithmetic on both JREL and NEXT.
    instr(3'd2, 16'h0010, 16'hB001);
    chk("jabs_10", pc, 16'h0010);
    instr(3'd1, 16'hFFF0, 16'hB002);
    chk("jrel_wrap", pc, 16'h0000);
    instr(3'd2, 16'hFFFF, 16'hB003);
    instr(3'd0, 16'h0, 16'hB004);
    chk("next_wrap", pc, 16'h0000);

    // Call and return.
    instr(3'd2, 16'h0020, 16'hC001);
    instr(3'd3, 16'h0100, 16'hC002);
    chk("call_fetch", mem_addr, 16'h0100);
    instr(3'd4, 16'h0, 16'hC003);
    chk("ret_fetch", mem_addr, 16'h0021);
    instr(3'd6, 16'h5555, 16'hC004);
    chk("reserved_next", pc, 16'h0022);

    // Memory stall with a stray exec_done: address holds, no ir_valid.
    exec_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_addr", mem_addr, 16'h0022);
      chk("stall_ir_valid", ir_valid, 1'b0);
    end
    exec_done = 1'b0;
    instr(3'd0, 16'h0, 16'hD001);

    // HALT op: stops without error and ignores all inputs afterwards.
    instr(3'd5, 16'h0, 16'hD002);
    chk("halt_halted", halted, 1'b1);
    chk("halt_err", stack_err, 1'b0);
    start = 1'b1; mem_ready = 1'b1; exec_done = 1'b1; pc_op = 3'd4;
    for (int k = 0; k < 3; k++) tick();
    chk("halt_pc", pc, 16'h0023);
    chk("halt_mem_rd", mem_rd, 1'b0);

    // Five nested calls at depth 4.
    do_reset(); go();
    instr(3'd3, 16'h0010, 16'hE001);
    instr(3'd3, 16'h0020, 16'hE002);
    instr(3'd3, 16'h0030, 16'hE003);
    instr(3'd3, 16'h0040, 16'hE004);
    chk("depth4_running", halted, 1'b0);
    instr(3'd3, 16'h0050, 16'hE005);
    chk("ovf_err", stack_err, 1'b1);
    chk("ovf_halted", halted, 1'b1);
    chk("ovf_pc", pc, 16'h0040);
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin tick(); chk("ovf_mem_rd", mem_rd, 1'b0); end
    mem_ready = 1'b0;

    // Return with nothing on the stack.
    do_reset(); go();
    instr(3'd4, 16'h0, 16'hE101);
    chk("unf_err", stack_err, 1'b1);
    chk("unf_halted", halted, 1'b1);
    chk("unf_pc", pc, 16'h0000);

    // Reset mid-fetch with two return addresses stacked.
    do_reset(); go();
    instr(3'd3, 16'h0100, 16'hF001);
    instr(3'd3, 16'h0200, 16'hF002);
    tick();
    chk("pre_rst_mem_rd", mem_rd, 1'b1);
    chk("pre_rst_addr", mem_addr, 16'h0200);
    #2 rst_n = 1'b0;
    #1 reset_pins("midfetch");
    tick(); tick();
    rst_n = 1'b1;
    go();
    chk("post_rst_addr", mem_addr, 16'h0000);
    instr(3'd4, 16'h0, 16'hF003);
    chk("post_rst_stack_empty", stack_err, 1'b1);
    chk("post_rst_halted", halted, 1'b1);

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
